// File: rtl/seg_scan_if.sv
// Scan-bus bundle between a scanned 7-segment display controller and the receive-side decoder.
// Optional dp capture port is present when SEG_DP_CAPTURE_EN is defined.
interface seg_scan_if;
    logic [7:0]  led_en;
    logic [7:0]  led_cx;
    logic [31:0] display;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        bad_code;
    logic        en_err;
    logic        blank;
`ifdef SEG_DP_CAPTURE_EN
    logic [7:0]  dp_out;

    modport master (output led_en, led_cx,
                    input  display, digit_valid, frame_done, bad_code, en_err, blank, dp_out);
    modport slave  (input  led_en, led_cx,
                    output display, digit_valid, frame_done, bad_code, en_err, blank, dp_out);
`else
    modport master (output led_en, led_cx,
                    input  display, digit_valid, frame_done, bad_code, en_err, blank);
    modport slave  (input  led_en, led_cx,
                    output display, digit_valid, frame_done, bad_code, en_err, blank);
`endif
endinterface

// File: rtl/seg_scan_decoder.sv
// Scanned 7-segment receiver: deglitches led_en/led_cx, decodes digits to hex and rebuilds the word.
// Define SEG_DP_CAPTURE_EN to also capture decimal points into dp_out.
module seg_scan_decoder #(
    parameter int STABLE_CYC = 4,
    parameter int STALE_MAX  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int DW = $clog2(STALE_MAX + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(STABLE_CYC - 1);
    localparam logic [DW-1:0] STALE_V     = DW'(STALE_MAX);
    localparam logic [DW-1:0] STALE_PRE   = DW'(STALE_MAX - 1);

    typedef enum logic [1:0] {SETTLE, CAPTURE, HOLD} state_t;

    // Returns {valid, nibble}; anything not in the hex set decodes to 0/invalid.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h40: seg_decode = 5'h10;
            7'h79: seg_decode = 5'h11;
            7'h24: seg_decode = 5'h12;
            7'h30: seg_decode = 5'h13;
            7'h19: seg_decode = 5'h14;
            7'h12: seg_decode = 5'h15;
            7'h02: seg_decode = 5'h16;
            7'h78: seg_decode = 5'h17;
            7'h00: seg_decode = 5'h18;
            7'h10: seg_decode = 5'h19;
            7'h08: seg_decode = 5'h1A;
            7'h03: seg_decode = 5'h1B;
            7'h46: seg_decode = 5'h1C;
            7'h21: seg_decode = 5'h1D;
            7'h06: seg_decode = 5'h1E;
            7'h0E: seg_decode = 5'h1F;
            default: seg_decode = 5'h00;
        endcase
    endfunction

    state_t          state;
    logic [SW-1:0]   cnt;
    logic [DW-1:0]   dark;
    logic [15:0]     in_q, in_prev;
    logic [7:0][3:0] shadow;
    logic [7:0]      shadow_valid;
    logic [7:0]      seen;
`ifdef SEG_DP_CAPTURE_EN
    logic [7:0]      shadow_dp;
`endif

    logic [7:0] en_q, cx_q;
    logic [4:0] dec;
    logic       changed, en_onehot, en_idle, seg_blank;

    assign en_q      = in_q[15:8];
    assign cx_q      = in_q[7:0];
    assign changed   = (in_q != in_prev);
    assign en_onehot = $onehot(~en_q);
    assign en_idle   = (en_q == 8'hFF);
    assign dec       = seg_decode(cx_q[6:0]);
    assign seg_blank = (cx_q[6:0] == 7'h7F);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Input history resets to the idle bus so reset itself never looks like a selection.
            in_q            <= '1;
            in_prev         <= '1;
            state           <= SETTLE;
            cnt             <= '0;
            dark            <= '0;
            shadow          <= '0;
            shadow_valid    <= '0;
            seen            <= '0;
            bus.display     <= '0;
            bus.digit_valid <= '0;
            bus.frame_done  <= 1'b0;
            bus.bad_code    <= 1'b0;
            bus.en_err      <= 1'b0;
            bus.blank       <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
            shadow_dp       <= '0;
            bus.dp_out      <= '0;
`endif
        end else begin
            in_q           <= {bus.led_en, bus.led_cx};
            in_prev        <= in_q;
            bus.frame_done <= 1'b0;
            bus.bad_code   <= 1'b0;
            bus.en_err     <= 1'b0;

            if (changed) begin
                state <= SETTLE;
                cnt   <= '0;
            end else begin
                case (state)
                    SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            // Capture edge: the selection has been stable long enough.
                            state <= CAPTURE;
                            if (en_onehot) begin
                                for (int i = 0; i < 8; i++) begin
                                    if (!en_q[i]) begin
                                        shadow[i]       <= dec[3:0];
                                        shadow_valid[i] <= dec[4];
                                        seen[i]         <= 1'b1;
`ifdef SEG_DP_CAPTURE_EN
                                        shadow_dp[i]    <= ~cx_q[7];
`endif
                                    end
                                end
                                bus.bad_code <= !dec[4] && !seg_blank;
                            end else if (!en_idle) begin
                                bus.en_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    CAPTURE: state <= HOLD;
                    default: state <= HOLD;
                endcase
            end

            // The last capture leaves the FSM in CAPTURE, so commit never coincides with a capture.
            if (seen == 8'hFF) begin
                bus.display     <= shadow;
                bus.digit_valid <= shadow_valid;
                bus.frame_done  <= 1'b1;
                seen            <= '0;
`ifdef SEG_DP_CAPTURE_EN
                bus.dp_out      <= shadow_dp;
`endif
            end

            if (en_idle) begin
                if (dark != STALE_V) dark <= dark + 1'b1;
                if (dark >= STALE_PRE) begin
                    bus.blank <= 1'b1;
                    seen      <= '0;
                end
            end else begin
                dark      <= '0;
                bus.blank <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: frames are queued as digits are scanned and
// checked when frame_done fires; pulse counters check bad_code/en_err/blank behaviour.
module tb_seg_scan_decoder;
    localparam int STB = 4;
    localparam int STL = 40;

    typedef struct packed {
        logic [31:0] disp;
        logic [7:0]  vld;
        logic [7:0]  dp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_scan_if bus();

    seg_scan_decoder #(.STABLE_CYC(STB), .STALE_MAX(STL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_frames = 0;
    int   n_badcode = 0;
    int   n_enerr = 0;

    function automatic logic [6:0] hex2seg(input logic [3:0] n);
        case (n)
            4'h0: hex2seg = 7'h40; 4'h1: hex2seg = 7'h79; 4'h2: hex2seg = 7'h24; 4'h3: hex2seg = 7'h30;
            4'h4: hex2seg = 7'h19; 4'h5: hex2seg = 7'h12; 4'h6: hex2seg = 7'h02; 4'h7: hex2seg = 7'h78;
            4'h8: hex2seg = 7'h00; 4'h9: hex2seg = 7'h10; 4'hA: hex2seg = 7'h08; 4'hB: hex2seg = 7'h03;
            4'hC: hex2seg = 7'h46; 4'hD: hex2seg = 7'h21; 4'hE: hex2seg = 7'h06; default: hex2seg = 7'h0E;
        endcase
    endfunction

    // Frame scoreboard and pulse counters, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (bus.frame_done === 1'b1) begin
            exp_t e;
            n_frames++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL frame_unexpected display=%h digit_valid=%h (no frame expected)",
                         bus.display, bus.digit_valid);
            end else begin
                e = exp_q.pop_front();
                if (bus.display !== e.disp || bus.digit_valid !== e.vld) begin
                    n_bad++;
                    $display("FAIL frame_data display=%h digit_valid=%h expected %h / %h",
                             bus.display, bus.digit_valid, e.disp, e.vld);
                end
`ifdef SEG_DP_CAPTURE_EN
                n_cmp++;
                if (bus.dp_out !== e.dp) begin
                    n_bad++;
                    $display("FAIL frame_dp dp_out=%h expected %h", bus.dp_out, e.dp);
                end
`endif
            end
        end
        if (bus.bad_code === 1'b1) n_badcode++;
        if (bus.en_err === 1'b1) n_enerr++;
    end

    task automatic idle(input int cyc);
        bus.led_en = 8'hFF;
        bus.led_cx = 8'hFF;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.led_en = 8'hFF;
        bus.led_cx = 8'hFF;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic show_digit(input int d, input logic [7:0] cx, input int hold);
        logic [7:0] one;
        one = 8'h01 << d;
        bus.led_en = ~one;
        bus.led_cx = cx;
        repeat (hold) @(negedge clk);
    endtask

    task automatic scan_word(input logic [31:0] val, input logic [7:0] dp, input int hold);
        for (int d = 7; d >= 0; d--)
            show_digit(d, {~dp[d], hex2seg(val[d*4 +: 4])}, hold);
    endtask

    task automatic drain(input string name);
        idle(20);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain pending frames=%0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bus.display !== 32'h0 || bus.digit_valid !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_regs display=%h digit_valid=%h expected 0/0", bus.display, bus.digit_valid);
        end
        n_cmp++;
        if ({bus.frame_done, bus.bad_code, bus.en_err, bus.blank} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_pulses fd/bc/ee/bl=%b expected 0000",
                     {bus.frame_done, bus.bad_code, bus.en_err, bus.blank});
        end
    endtask

    task automatic test_basic();
        int f0, b0;
        do_reset();
        f0 = n_frames; b0 = n_badcode;
        exp_q.push_back('{32'h12345678, 8'hFF, 8'h00});
        scan_word(32'h12345678, 8'h00, 10);
        drain("basic");
        n_cmp++;
        if (n_frames - f0 != 1 || n_badcode != b0) begin
            n_bad++;
            $display("FAIL basic_counts frames=%0d bad_code=%0d expected 1/0", n_frames - f0, n_badcode - b0);
        end
    endtask

    task automatic test_short_hold();
        int f0;
        do_reset();
        f0 = n_frames;
        scan_word(32'h12345678, 8'h00, STB - 1);
        scan_word(32'h12345678, 8'h00, STB - 1);
        idle(20);
        n_cmp++;
        if (n_frames != f0 || bus.display !== 32'h0 || bus.digit_valid !== 8'h0) begin
            n_bad++;
            $display("FAIL short_hold frames=%0d display=%h expected 0/00000000", n_frames - f0, bus.display);
        end
    endtask

    task automatic test_boundary_hold();
        do_reset();
        exp_q.push_back('{32'hDEADBEEF, 8'hFF, 8'h00});
        exp_q.push_back('{32'hCAFE0123, 8'hFF, 8'h00});
        scan_word(32'hDEADBEEF, 8'h00, STB + 1);
        scan_word(32'hCAFE0123, 8'h00, STB + 1);
        drain("back_to_back");
    endtask

    task automatic test_bad_codes();
        int b0;
        do_reset();
        b0 = n_badcode;
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back('{32'h88080888, 8'hD7, 8'h00});
            for (int d = 7; d >= 0; d--)
                show_digit(d, (d == 3) ? 8'hFF : (d == 5) ? 8'hFE : 8'h80, 10);
        end
        drain("bad_codes");
        n_cmp++;
        if (n_badcode - b0 != 2) begin
            n_bad++;
            $display("FAIL bad_code_pulses count=%0d expected 2", n_badcode - b0);
        end
    endtask

    task automatic test_en_err();
        int e0, f0;
        logic [31:0] v;
        v = 32'h9E107BD4;
        do_reset();
        e0 = n_enerr; f0 = n_frames;
        for (int d = 0; d < 4; d++) show_digit(d, {1'b1, hex2seg(v[d*4 +: 4])}, 10);
        bus.led_en = 8'hFC;
        bus.led_cx = 8'h80;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (n_enerr - e0 != 1 || n_frames != f0) begin
            n_bad++;
            $display("FAIL en_err_pulse en_err=%0d frames=%0d expected 1/0", n_enerr - e0, n_frames - f0);
        end
        exp_q.push_back('{v, 8'hFF, 8'h00});
        for (int d = 7; d >= 4; d--) show_digit(d, {1'b1, hex2seg(v[d*4 +: 4])}, 10);
        drain("en_err");
    endtask

    task automatic test_blank();
        int f0;
        logic [31:0] v;
        v = 32'h76543210;
        do_reset();
        exp_q.push_back('{32'h0F1E2D3C, 8'hFF, 8'h00});
        scan_word(32'h0F1E2D3C, 8'h00, 10);
        for (int d = 0; d < 4; d++) show_digit(d, {1'b1, hex2seg(v[d*4 +: 4])}, 10);
        idle(STL + 5);
        f0 = n_frames;
        n_cmp++;
        if (bus.blank !== 1'b1 || bus.display !== 32'h0F1E2D3C) begin
            n_bad++;
            $display("FAIL blank_assert blank=%b display=%h expected 1/0f1e2d3c", bus.blank, bus.display);
        end
        bus.led_en = 8'h7F;
        bus.led_cx = {1'b1, hex2seg(v[31:28])};
        @(negedge clk);
        n_cmp++;
        if (bus.blank !== 1'b1) begin
            n_bad++;
            $display("FAIL blank_hold blank=%b expected 1", bus.blank);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.blank !== 1'b0) begin
            n_bad++;
            $display("FAIL blank_release blank=%b expected 0", bus.blank);
        end
        repeat (8) @(negedge clk);
        for (int d = 6; d >= 4; d--) show_digit(d, {1'b1, hex2seg(v[d*4 +: 4])}, 10);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (n_frames != f0) begin
            n_bad++;
            $display("FAIL blank_discard frames=%0d expected 0 before recapture", n_frames - f0);
        end
        exp_q.push_back('{v, 8'hFF, 8'h00});
        for (int d = 3; d >= 0; d--) show_digit(d, {1'b1, hex2seg(v[d*4 +: 4])}, 10);
        drain("blank");
    endtask

    task automatic test_reset_midframe();
        int f0;
        logic [31:0] v;
        v = 32'hB00C5A1F;
        do_reset();
        exp_q.push_back('{32'h13579BDF, 8'hFF, 8'h00});
        scan_word(32'h13579BDF, 8'h00, 10);
        for (int d = 7; d >= 4; d--) show_digit(d, {1'b1, hex2seg(v[d*4 +: 4])}, 10);
        drain("pre_reset");
        do_reset();
        n_cmp++;
        if (bus.display !== 32'h0 || bus.digit_valid !== 8'h0) begin
            n_bad++;
            $display("FAIL midreset_regs display=%h digit_valid=%h expected 0/0", bus.display, bus.digit_valid);
        end
        f0 = n_frames;
        for (int d = 3; d >= 0; d--) show_digit(d, {1'b1, hex2seg(v[d*4 +: 4])}, 10);
        idle(10);
        n_cmp++;
        if (n_frames != f0) begin
            n_bad++;
            $display("FAIL midreset_partial frames=%0d expected 0", n_frames - f0);
        end
        exp_q.push_back('{v, 8'hFF, 8'h00});
        scan_word(v, 8'h00, 10);
        drain("midreset");
    endtask

    task automatic test_dp();
        int b0;
        do_reset();
        b0 = n_badcode;
        exp_q.push_back('{32'h5A5AA5A5, 8'hFF, 8'h11});
        scan_word(32'h5A5AA5A5, 8'h11, 10);
        drain("dp");
        n_cmp++;
        if (n_badcode != b0) begin
            n_bad++;
            $display("FAIL dp_bad_code count=%0d expected 0", n_badcode - b0);
        end
    endtask

    initial begin
        bus.led_en = 8'hFF;
        bus.led_cx = 8'hFF;
        test_reset();
        test_basic();
        test_short_hold();
        test_boundary_hold();
        test_bad_codes();
        test_en_err();
        test_blank();
        test_reset_midframe();
        test_dp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
